// File: rtl/pong_pkg.sv
// Shared Pong definitions: coordinate width, screen geometry and the
// serve/run state encoding used by every moving object.
package pong_pkg;
  localparam int COORD_W  = 10;
  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int BORDER_W = 2;

  typedef enum logic {SERVE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic left;
    logic right;
    logic top;
    logic bot;
  } walls_t;
endpackage

// File: rtl/moving_box_if.sv
// Scan/control bundle between the VGA timing side and a moving box object.
interface moving_box_if #(parameter int COORD_W = pong_pkg::COORD_W);
  logic               enable;
  logic               frame_tick;
  logic               serve;
  logic               paddle_hit;
  logic [COORD_W-1:0] X_pix;
  logic [COORD_W-1:0] Y_pix;
  logic               box;
  logic [COORD_W-1:0] box_x;
  logic [COORD_W-1:0] box_y;
  logic               wall_left;
  logic               wall_right;
  logic               wall_top;
  logic               wall_bot;
  logic               moving;

  modport master (
    output enable, frame_tick, serve, paddle_hit, X_pix, Y_pix,
    input  box, box_x, box_y, wall_left, wall_right, wall_top, wall_bot, moving
  );

  modport slave (
    input  enable, frame_tick, serve, paddle_hit, X_pix, Y_pix,
    output box, box_x, box_y, wall_left, wall_right, wall_top, wall_bot, moving
  );
endinterface

// File: rtl/box_hit.sv
// Registered "scan pixel inside rectangle" test; shared by ball, paddles and borders.
module box_hit #(
  parameter int COORD_W = pong_pkg::COORD_W,
  parameter int BOX_W   = 5,
  parameter int BOX_H   = 5
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] X_pix,
  input  logic [COORD_W-1:0] Y_pix,
  input  logic [COORD_W-1:0] box_x,
  input  logic [COORD_W-1:0] box_y,
  output logic               hit
);
  // One extra bit so the exclusive right/bottom edge never wraps.
  localparam logic [COORD_W:0] W_EXT = (COORD_W+1)'(BOX_W);
  localparam logic [COORD_W:0] H_EXT = (COORD_W+1)'(BOX_H);

  logic [COORD_W:0] px, py, x0, y0;

  assign px = {1'b0, X_pix};
  assign py = {1'b0, Y_pix};
  assign x0 = {1'b0, box_x};
  assign y0 = {1'b0, box_y};

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) hit <= 1'b0;
    else     hit <= (px >= x0) && (px < x0 + W_EXT) && (py >= y0) && (py < y0 + H_EXT);
  end
endmodule

// File: rtl/moving_box.sv
// Frame-stepped bouncing rectangle: serve hold, wall bounce, paddle reversal,
// and a registered per-pixel hit flag for the colour mux.
module moving_box #(
  parameter int COORD_W      = pong_pkg::COORD_W,
  parameter int BOX_W        = 5,
  parameter int BOX_H        = 5,
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int X_MIN        = 2,
  parameter int X_MAX        = 637,
  parameter int Y_MIN        = 2,
  parameter int Y_MAX        = 477,
  parameter int STEP_X       = 2,
  parameter int STEP_Y       = 1,
  parameter int FRAME_DIV    = 1,
  parameter int SERVE_FRAMES = 60
) (
  input  logic         pixel_clk,
  input  logic         rst,
  moving_box_if.slave  bus
);
  import pong_pkg::*;

  if (X_MAX - X_MIN + 1 < BOX_W || Y_MAX - Y_MIN + 1 < BOX_H) begin : g_bad_bounds
    $error("moving_box: play area smaller than the box");
  end
  if (FRAME_DIV < 1 || SERVE_FRAMES < 1 || BOX_W < 1 || BOX_H < 1) begin : g_bad_counts
    $error("moving_box: FRAME_DIV, SERVE_FRAMES, BOX_W and BOX_H must be >= 1");
  end

  localparam int FC_W = $clog2(FRAME_DIV + 1);
  localparam int SC_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [FC_W-1:0]    FC_LAST = FC_W'(FRAME_DIV - 1);
  localparam logic [SC_W-1:0]    SC_LAST = SC_W'(SERVE_FRAMES - 1);
  localparam logic [COORD_W-1:0] X0      = COORD_W'(X_INIT);
  localparam logic [COORD_W-1:0] Y0      = COORD_W'(Y_INIT);

  state_t             state, state_n;
  logic [FC_W-1:0]    frame_cnt, frame_cnt_n;
  logic [SC_W-1:0]    serve_cnt, serve_cnt_n;
  logic               move, tick;
  logic [COORD_W-1:0] box_x, box_y, nx, ny;
  logic               dir_x, dir_y, ndx, ndy, hit_pend, hit;
  walls_t             walls, walls_n;

  // Signed step with clamp-and-reflect at either bound; dir 0 = increasing.
  function automatic void step_axis(
    input  logic [COORD_W-1:0] pos,
    input  logic               dir,
    input  int                 step, size, lo, hi,
    output logic [COORD_W-1:0] npos,
    output logic               ndir,
    output logic               hit_lo,
    output logic               hit_hi
  );
    int n;
    n      = dir ? int'(pos) - step : int'(pos) + step;
    npos   = COORD_W'(n);
    ndir   = dir;
    hit_lo = 1'b0;
    hit_hi = 1'b0;
    if (!dir && n + size - 1 > hi) begin
      npos   = COORD_W'(hi - size + 1);
      ndir   = 1'b1;
      hit_hi = 1'b1;
    end else if (dir && n < lo) begin
      npos   = COORD_W'(lo);
      ndir   = 1'b0;
      hit_lo = 1'b1;
    end
  endfunction

  assign tick = bus.enable & bus.frame_tick;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state     <= SERVE;
      frame_cnt <= '0;
      serve_cnt <= '0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_cnt_n;
      serve_cnt <= serve_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    serve_cnt_n = serve_cnt;
    move        = 1'b0;
    if (bus.serve) begin
      state_n     = SERVE;
      frame_cnt_n = '0;
      serve_cnt_n = '0;
    end else if (tick) begin
      case (state)
        SERVE: begin
          if (serve_cnt == SC_LAST) begin
            serve_cnt_n = '0;
            state_n     = RUN;
          end else begin
            serve_cnt_n = serve_cnt + 1'b1;
          end
        end
        RUN: begin
          if (frame_cnt == FC_LAST) begin
            frame_cnt_n = '0;
            move        = 1'b1;
          end else begin
            frame_cnt_n = frame_cnt + 1'b1;
          end
        end
        default: state_n = SERVE;
      endcase
    end
  end

  // A pending paddle hit flips X before the step so a wall can still clamp it.
  always_comb begin
    walls_n = '0;
    step_axis(box_x, dir_x ^ hit_pend, STEP_X, BOX_W, X_MIN, X_MAX,
              nx, ndx, walls_n.left, walls_n.right);
    step_axis(box_y, dir_y, STEP_Y, BOX_H, Y_MIN, Y_MAX,
              ny, ndy, walls_n.top, walls_n.bot);
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      box_x    <= X0;
      box_y    <= Y0;
      dir_x    <= 1'b0;
      dir_y    <= 1'b0;
      hit_pend <= 1'b0;
      walls    <= '0;
    end else if (bus.serve) begin
      box_x    <= X0;
      box_y    <= Y0;
      hit_pend <= 1'b0;
      walls    <= '0;
    end else if (move) begin
      box_x    <= nx;
      box_y    <= ny;
      dir_x    <= ndx;
      dir_y    <= ndy;
      hit_pend <= bus.paddle_hit;
      walls    <= walls_n;
    end else begin
      hit_pend <= hit_pend | bus.paddle_hit;
      walls    <= '0;
    end
  end

  box_hit #(.COORD_W(COORD_W), .BOX_W(BOX_W), .BOX_H(BOX_H)) u_hit (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .X_pix     (bus.X_pix),
    .Y_pix     (bus.Y_pix),
    .box_x     (box_x),
    .box_y     (box_y),
    .hit       (hit)
  );

  assign bus.box        = hit;
  assign bus.box_x      = box_x;
  assign bus.box_y      = box_y;
  assign bus.wall_left  = walls.left;
  assign bus.wall_right = walls.right;
  assign bus.wall_top   = walls.top;
  assign bus.wall_bot   = walls.bot;
  assign bus.moving     = (state == RUN);
endmodule

// File: tb/tb_moving_box.sv
// Four moving_box instances (centre serve, right wall, corner, paddle) checked
// every cycle against a plain-arithmetic model, plus hand-computed spot checks.
module tb_moving_box;
  localparam int N = 4;
  localparam int BW = 5, BH = 5, XMIN = 2, XMAX = 637, YMIN = 2, YMAX = 477;
  localparam int SX = 2, SY = 1, FD = 1;

  function automatic int xi(int g);
    case (g)
      0: return 320;
      1: return 631;
      2: return 633;
      default: return 400;
    endcase
  endfunction
  function automatic int yi(int g);
    return (g == 2) ? 473 : 240;
  endfunction
  function automatic int sf(int g);
    return (g == 0) ? 60 : 1;
  endfunction

  logic pixel_clk = 1'b0;
  logic rst = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  logic       en[N], ft[N], sv[N], ph[N];
  logic [9:0] xp, yp;
  logic       box_o[N], wl_o[N], wr_o[N], wt_o[N], wb_o[N], mv_o[N];
  logic [9:0] bx_o[N], by_o[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    moving_box_if ifc ();
    assign ifc.enable     = en[g];
    assign ifc.frame_tick = ft[g];
    assign ifc.serve      = sv[g];
    assign ifc.paddle_hit = ph[g];
    assign ifc.X_pix      = xp;
    assign ifc.Y_pix      = yp;
    assign box_o[g] = ifc.box;
    assign bx_o[g]  = ifc.box_x;
    assign by_o[g]  = ifc.box_y;
    assign wl_o[g]  = ifc.wall_left;
    assign wr_o[g]  = ifc.wall_right;
    assign wt_o[g]  = ifc.wall_top;
    assign wb_o[g]  = ifc.wall_bot;
    assign mv_o[g]  = ifc.moving;

    moving_box #(.X_INIT(xi(g)), .Y_INIT(yi(g)), .SERVE_FRAMES(sf(g))) dut (
      .pixel_clk (pixel_clk),
      .rst       (rst),
      .bus       (ifc)
    );
  end

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, int g, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s[dut%0d] got=%0d want=%0d at %0t", nm, g, got, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int mx[N], my[N], ticks[N];
  bit mdx[N], mdy[N], mrun[N], mhp[N], mbox[N], mwl[N], mwr[N], mwt[N], mwb[N];

  function automatic void axis(input int p, input bit d, input int s, input int sz,
                               input int lo, input int hi,
                               output int np, output bit nd, output bit wlo, output bit whi);
    int t;
    t = d ? p - s : p + s;
    np = t; nd = d; wlo = 1'b0; whi = 1'b0;
    if (t > hi - sz + 1) begin
      np = hi - sz + 1; nd = 1'b1; whi = 1'b1;
    end else if (t < lo) begin
      np = lo; nd = 1'b0; wlo = 1'b1;
    end
  endfunction

  always @(posedge pixel_clk or posedge rst) begin
    int  np;
    bit  nd, wlo, whi, mv;
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        mx[g] = xi(g); my[g] = yi(g); mdx[g] = 0; mdy[g] = 0; mrun[g] = 0;
        ticks[g] = 0; mhp[g] = 0; mbox[g] = 0;
        mwl[g] = 0; mwr[g] = 0; mwt[g] = 0; mwb[g] = 0;
      end else begin
        mbox[g] = (int'(xp) >= mx[g]) && (int'(xp) < mx[g] + BW) &&
                  (int'(yp) >= my[g]) && (int'(yp) < my[g] + BH);
        mwl[g] = 0; mwr[g] = 0; mwt[g] = 0; mwb[g] = 0;
        if (sv[g]) begin
          mx[g] = xi(g); my[g] = yi(g); mrun[g] = 0; ticks[g] = 0; mhp[g] = 0;
        end else begin
          mv = 1'b0;
          if (en[g] && ft[g]) begin
            ticks[g]++;
            if (!mrun[g]) begin
              if (ticks[g] == sf(g)) begin
                mrun[g] = 1; ticks[g] = 0;
              end
            end else begin
              mv = (ticks[g] % FD == 0);
            end
          end
          if (mv) begin
            axis(mx[g], mdx[g] ^ mhp[g], SX, BW, XMIN, XMAX, np, nd, wlo, whi);
            mx[g] = np; mdx[g] = nd; mwl[g] = wlo; mwr[g] = whi;
            axis(my[g], mdy[g], SY, BH, YMIN, YMAX, np, nd, wlo, whi);
            my[g] = np; mdy[g] = nd; mwt[g] = wlo; mwb[g] = whi;
            mhp[g] = ph[g];
          end else if (ph[g]) begin
            mhp[g] = 1;
          end
        end
      end
    end
  end

  always @(negedge pixel_clk) begin
    for (int g = 0; g < N; g++) begin
      chk("box",        g, box_o[g], mbox[g]);
      chk("box_x",      g, bx_o[g],  mx[g]);
      chk("box_y",      g, by_o[g],  my[g]);
      chk("wall_left",  g, wl_o[g],  mwl[g]);
      chk("wall_right", g, wr_o[g],  mwr[g]);
      chk("wall_top",   g, wt_o[g],  mwt[g]);
      chk("wall_bot",   g, wb_o[g],  mwb[g]);
      chk("moving",     g, mv_o[g],  mrun[g]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge pixel_clk);
    #2;
  endtask

  task automatic tick(input logic [N-1:0] m);
    cyc();
    for (int g = 0; g < N; g++) ft[g] = m[g];
    cyc();
    for (int g = 0; g < N; g++) ft[g] = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input int exp);
    xp = 10'(x); yp = 10'(y);
    cyc();
    chk("lit_box", 0, box_o[0], exp);
  endtask

  initial begin
    for (int g = 0; g < N; g++) begin
      en[g] = 1'b1; ft[g] = 1'b0; sv[g] = 1'b0; ph[g] = 1'b0;
    end
    xp = '0; yp = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_box_x", 0, bx_o[0], 320);
    chk("rst_box_y", 0, by_o[0], 240);
    chk("rst_moving", 0, mv_o[0], 0);
    chk("rst_box", 0, box_o[0], 0);
    chk("rst_box_x", 1, bx_o[1], 631);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // raster sweep around the served box
    for (int y = 238; y <= 246; y++)
      for (int x = 317; x <= 327; x++) begin
        xp = 10'(x); yp = 10'(y);
        cyc();
      end
    pix(320, 240, 1);
    pix(324, 244, 1);
    pix(322, 242, 1);
    pix(325, 240, 0);
    pix(319, 240, 0);
    pix(320, 245, 0);
    xp = '0; yp = '0;

    // SERVE_FRAMES=1 instances start running
    tick(4'b1110);
    chk("lit_moving", 1, mv_o[1], 1);
    chk("lit_box_x", 1, bx_o[1], 631);

    // right wall approach and bounce
    tick(4'b0010);
    chk("lit_box_x", 1, bx_o[1], 633);
    chk("lit_wall_right", 1, wr_o[1], 0);
    tick(4'b0010);
    chk("lit_box_x", 1, bx_o[1], 633);
    chk("lit_wall_right", 1, wr_o[1], 1);
    cyc();
    chk("lit_wall_right_end", 1, wr_o[1], 0);
    tick(4'b0010);
    chk("lit_box_x", 1, bx_o[1], 631);

    // corner: both walls together, both directions reverse
    tick(4'b0100);
    chk("lit_wall_right", 2, wr_o[2], 1);
    chk("lit_wall_bot", 2, wb_o[2], 1);
    chk("lit_box_x", 2, bx_o[2], 633);
    chk("lit_box_y", 2, by_o[2], 473);
    tick(4'b0100);
    chk("lit_box_x", 2, bx_o[2], 631);
    chk("lit_box_y", 2, by_o[2], 472);

    // two paddle hits before one move: single reversal
    ph[3] = 1'b1; cyc(); ph[3] = 1'b0; cyc();
    ph[3] = 1'b1; cyc(); ph[3] = 1'b0;
    tick(4'b1000);
    chk("lit_paddle_x", 3, bx_o[3], 398);
    tick(4'b1000);
    chk("lit_paddle_x", 3, bx_o[3], 396);

    // serve keeps direction (dut1 is travelling left)
    sv[1] = 1'b1; cyc(); sv[1] = 1'b0;
    chk("lit_serve_x", 1, bx_o[1], 631);
    tick(4'b0010);
    tick(4'b0010);
    chk("lit_dir_kept", 1, bx_o[1], 629);

    // 60-frame serve hold on the default instance
    repeat (59) tick(4'b0001);
    chk("lit_moving", 0, mv_o[0], 0);
    tick(4'b0001);
    chk("lit_moving", 0, mv_o[0], 1);
    chk("lit_box_x", 0, bx_o[0], 320);
    tick(4'b0001);
    chk("lit_box_x", 0, bx_o[0], 322);
    chk("lit_box_y", 0, by_o[0], 241);

    // enable low ignores frame_tick
    en[0] = 1'b0;
    tick(4'b0001);
    chk("lit_frozen_x", 0, bx_o[0], 322);
    en[0] = 1'b1;

    // serve wins over a coincident frame_tick
    cyc();
    sv[0] = 1'b1; ft[0] = 1'b1;
    cyc();
    sv[0] = 1'b0; ft[0] = 1'b0;
    chk("lit_serve_x", 0, bx_o[0], 320);
    chk("lit_serve_y", 0, by_o[0], 240);
    chk("lit_serve_moving", 0, mv_o[0], 0);
    tick(4'b0001);
    chk("lit_serve_hold", 0, bx_o[0], 320);

    // asynchronous reset between clock edges
    cyc();
    #1 rst = 1'b1;
    #1;
    chk("lit_async_x", 3, bx_o[3], 400);
    chk("lit_async_y", 3, by_o[3], 240);
    chk("lit_async_moving", 3, mv_o[3], 0);
    chk("lit_async_x", 1, bx_o[1], 631);
    cyc();
    rst = 1'b0;
    tick(4'b1000);
    tick(4'b1000);
    chk("lit_dir_reset", 3, bx_o[3], 402);

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
